// File: rtl/sdram_burst_arbiter.sv
// sdram_burst_arbiter: shares one SDRAM burst controller between a read client
// (VGA line fetch) and a write client (UART pixel writer). One client is granted
// at a time. The burst command is held until the controller takes the first beat.
// Exactly BurstLength beats are routed to the granted client. The arbiter then
// waits for the controller to go idle before arbitrating again.
//
// Optional build macro ARB_ROUND_ROBIN_EN:
//   defined   - a last-winner flag alternates simultaneous requests; the flag
//               resets to "write last", so read wins the first tie.
//   undefined - fixed priority: read wins ties.
//
// Ports:
//   CLK, RST             clock; synchronous active-low reset
//   rd_req/rd_addr       read request and burst start address
//   rd_grant             1-cycle accept pulse for the read client
//   rd_valid/rd_data     read beat strobe and word
//   rd_done              1-cycle pulse after the last read beat
//   wr_req/wr_addr       write request and burst start address
//   wr_grant             1-cycle accept pulse for the write client
//   wr_data/wr_ack       write word and its consume strobe (combinational)
//   wr_done              1-cycle pulse after the last write beat
//   sd_enable/sd_rw/sd_addr/sd_data    command and write data to the controller
//   sd_rdata/sd_valid_wr/sd_valid_rd/sd_busy  controller responses
module sdram_burst_arbiter #(
  parameter int unsigned AddressWidth = 24,
  parameter int unsigned WordLength   = 16,
  parameter int unsigned BurstLength  = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    rd_req,
  input  logic [AddressWidth-1:0] rd_addr,
  output logic                    rd_grant,
  output logic                    rd_valid,
  output logic [WordLength-1:0]   rd_data,
  output logic                    rd_done,
  input  logic                    wr_req,
  input  logic [AddressWidth-1:0] wr_addr,
  output logic                    wr_grant,
  input  logic [WordLength-1:0]   wr_data,
  output logic                    wr_ack,
  output logic                    wr_done,
  output logic                    sd_enable,
  output logic                    sd_rw,
  output logic [AddressWidth-1:0] sd_addr,
  output logic [WordLength-1:0]   sd_data,
  input  logic [WordLength-1:0]   sd_rdata,
  input  logic                    sd_valid_wr,
  input  logic                    sd_valid_rd,
  input  logic                    sd_busy
);

  localparam int unsigned CntW = $clog2(BurstLength) + 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(BurstLength);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DRAIN} state_t;

  state_t          state;
  logic [CntW-1:0] count;
  logic            done_arm;   // DRAIN entry not yet signalled with a done pulse
  logic            active;
  logic            beat;
  logic            pick_rd;

  // Burst is owned by a client from command issue through the last beat.
  assign active = (state == ISSUE) || (state == XFER);
  // sd_rw holds the latched direction; only the matching strobe counts as a beat.
  assign beat   = sd_rw ? sd_valid_rd : sd_valid_wr;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_rd;  // 1: read won the previous arbitration
  assign pick_rd = rd_req && (!wr_req || !last_rd);
`else
  assign pick_rd = rd_req;
`endif

  // Combinational data paths.
  assign wr_ack  = active && !sd_rw && sd_valid_wr && (count < LastBeat);
  assign sd_data = (active && !sd_rw) ? wr_data : '0;
  assign rd_data = rd_valid ? sd_rdata : '0;

  // Arbitration and burst sequencing.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= IDLE;
      count     <= '0;
      done_arm  <= 1'b0;
      rd_grant  <= 1'b0;
      wr_grant  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_done   <= 1'b0;
      wr_done   <= 1'b0;
      sd_enable <= 1'b0;
      sd_rw     <= 1'b0;
      sd_addr   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_rd   <= 1'b0;
`endif
    end else begin
      rd_grant <= 1'b0;
      wr_grant <= 1'b0;
      rd_valid <= 1'b0;
      rd_done  <= 1'b0;
      wr_done  <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (!sd_busy && (rd_req || wr_req)) begin
            state     <= ISSUE;
            sd_enable <= 1'b1;
            sd_rw     <= pick_rd;
            sd_addr   <= pick_rd ? rd_addr : wr_addr;
            rd_grant  <= pick_rd;
            wr_grant  <= !pick_rd;
`ifdef ARB_ROUND_ROBIN_EN
            last_rd   <= pick_rd;
`endif
          end
        end
        // Enable is held through any refresh until the controller starts the burst.
        ISSUE: begin
          if (beat) begin
            sd_enable <= 1'b0;
            count     <= CntW'(1);
            rd_valid  <= sd_rw;
            if (LastBeat == CntW'(1)) begin
              state    <= DRAIN;
              done_arm <= 1'b1;
            end else begin
              state <= XFER;
            end
          end
        end
        XFER: begin
          if (beat && (count < LastBeat)) begin
            count    <= count + CntW'(1);
            rd_valid <= sd_rw;
            if ((count + CntW'(1)) == LastBeat) begin
              state    <= DRAIN;
              done_arm <= 1'b1;
            end
          end
        end
        // Done pulse lands one cycle after the last rd_valid; excess beats are ignored.
        DRAIN: begin
          if (done_arm) begin
            done_arm <= 1'b0;
            rd_done  <= sd_rw;
            wr_done  <= !sd_rw;
          end else if (!sd_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_burst_arbiter.sv
// Bench for sdram_burst_arbiter: SDRAM controller model (CL3 reads, optional
// refresh hold, configurable write-valid length), write client model, and a
// scoreboard of expected grants and data words.
module tb_sdram_burst_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        rd_req = 1'b0;
  logic [23:0] rd_addr = '0;
  logic        rd_grant, rd_valid, rd_done;
  logic [15:0] rd_data;
  logic        wr_req = 1'b0;
  logic [23:0] wr_addr = '0;
  logic        wr_grant, wr_ack, wr_done;
  logic [15:0] wr_data = '0;
  logic        sd_enable, sd_rw;
  logic [23:0] sd_addr;
  logic [15:0] sd_data;
  logic [15:0] sd_rdata = '0;
  logic        sd_valid_wr = 1'b0;
  logic        sd_valid_rd = 1'b0;
  logic        sd_busy = 1'b0;

  sdram_burst_arbiter dut (
    .CLK(CLK), .RST(RST),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_grant(wr_grant),
    .wr_data(wr_data), .wr_ack(wr_ack), .wr_done(wr_done),
    .sd_enable(sd_enable), .sd_rw(sd_rw), .sd_addr(sd_addr), .sd_data(sd_data),
    .sd_rdata(sd_rdata), .sd_valid_wr(sd_valid_wr), .sd_valid_rd(sd_valid_rd),
    .sd_busy(sd_busy)
  );

  always #5 CLK = ~CLK;

  // Controller model knobs, driven by the stimulus process.
  int wr_beats     = 8;
  bit refresh_next = 1'b0;

  // Controller model.
  logic [2:0]  m_phase  = '0;
  int          m_cnt    = 0;
  logic        m_rw     = 1'b0;
  logic [15:0] m_rd_idx = '0;
  bit          m_ref_used = 1'b0;

  always @(posedge CLK) begin
    sd_rdata <= sd_valid_rd ? (16'hA000 | m_rd_idx) : 16'h0000;
    if (sd_valid_rd) m_rd_idx <= m_rd_idx + 16'd1;
    case (m_phase)
      3'd0: begin
        sd_valid_rd <= 1'b0;
        sd_valid_wr <= 1'b0;
        if (!refresh_next) m_ref_used <= 1'b0;
        if (sd_enable) begin
          sd_busy <= 1'b1;
          if (refresh_next && !m_ref_used) begin
            m_ref_used <= 1'b1;
            m_cnt      <= 200;
            m_phase    <= 3'd1;
          end else begin
            m_rw     <= sd_rw;
            m_cnt    <= sd_rw ? 3 : 1;
            m_rd_idx <= '0;
            m_phase  <= 3'd2;
          end
        end
      end
      3'd1: begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          sd_busy <= 1'b0;
          m_phase <= 3'd0;
        end
      end
      3'd2: begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_phase <= 3'd3;
          m_cnt   <= m_rw ? 8 : wr_beats;
          if (m_rw) sd_valid_rd <= 1'b1;
          else      sd_valid_wr <= 1'b1;
        end
      end
      3'd3: begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          sd_valid_rd <= 1'b0;
          sd_valid_wr <= 1'b0;
          m_cnt       <= 3;
          m_phase     <= 3'd4;
        end
      end
      default: begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          sd_busy <= 1'b0;
          m_phase <= 3'd0;
        end
      end
    endcase
  end

  // Write client: restarts at 0x0001 on grant, advances on ack, holds after 0x0008.
  always @(posedge CLK) begin
    if (wr_grant) wr_data <= 16'h0001;
    else if (wr_ack && (wr_data < 16'h0008)) wr_data <= wr_data + 16'd1;
  end

  typedef struct packed {
    logic        rd;
    logic [23:0] addr;
  } grant_t;

  grant_t      gq[$];
  logic [15:0] rq[$];
  logic [15:0] wq[$];

  int n_checks = 0;
  int n_fail   = 0;
  int grants, rd_beats, wr_acks, wv_cycles, rd_dones, wr_dones;
  bit          busy_prev = 1'b0;
  bit          in_issue  = 1'b0;
  bit          hold_reqs = 1'b0;
  logic        cur_rw    = 1'b0;
  logic [23:0] cur_addr  = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_counts();
    grants = 0; rd_beats = 0; wr_acks = 0; wv_cycles = 0; rd_dones = 0; wr_dones = 0;
  endtask

  task automatic push_rd_burst();
    for (int i = 0; i < 8; i++) rq.push_back(16'(32'hA000 + i));
  endtask

  task automatic push_wr_burst();
    for (int i = 1; i <= 8; i++) wq.push_back(16'(i));
  endtask

  task automatic push_grant(input logic rd, input logic [23:0] addr);
    grant_t g;
    g.rd = rd;
    g.addr = addr;
    gq.push_back(g);
  endtask

  // Per-cycle observation of the DUT, sampled on the falling edge.
  task automatic monitor();
    grant_t g;
    if (rd_grant || wr_grant) begin
      grants++;
      check_eq("grant_while_busy", 32'(busy_prev), 32'd0);
      check_eq("grant_both", 32'(rd_grant && wr_grant), 32'd0);
      if (gq.size() == 0) begin
        check_eq("grant_unexpected", 32'({rd_grant, wr_grant}), 32'd0);
      end else begin
        g = gq.pop_front();
        check_eq("grant_kind_rd", 32'(rd_grant), 32'(g.rd));
        check_eq("grant_kind_wr", 32'(wr_grant), 32'(!g.rd));
        cur_rw   = g.rd;
        cur_addr = g.addr;
        in_issue = 1'b1;
      end
    end
    if (in_issue) begin
      check_eq("issue_enable", 32'(sd_enable), 32'd1);
      check_eq("issue_rw", 32'(sd_rw), 32'(cur_rw));
      check_eq("issue_addr", 32'(sd_addr), 32'(cur_addr));
      if (cur_rw ? sd_valid_rd : sd_valid_wr) in_issue = 1'b0;
    end else begin
      check_eq("enable_outside_issue", 32'(sd_enable), 32'd0);
    end
    if (rd_valid) begin
      rd_beats++;
      if (rq.size() == 0) check_eq("rd_extra_beat", 32'(rd_valid), 32'd0);
      else check_eq("rd_data", 32'(rd_data), 32'(rq.pop_front()));
    end
    if (wr_ack) begin
      wr_acks++;
      if (wq.size() == 0) check_eq("wr_extra_ack", 32'(wr_ack), 32'd0);
      else check_eq("sd_data", 32'(sd_data), 32'(wq.pop_front()));
    end
    if (sd_valid_wr) wv_cycles++;
    rd_dones += int'(rd_done);
    wr_dones += int'(wr_done);
    busy_prev = sd_busy;
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
    if (!hold_reqs) begin
      if (rd_grant) rd_req = 1'b0;
      if (wr_grant) wr_req = 1'b0;
    end
  endtask

  task automatic wait_dones(input int rd_t, input int wr_t, input int budget);
    int n = 0;
    while ((rd_dones < rd_t || wr_dones < wr_t) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check_eq("done_timeout", 32'(rd_dones + wr_dones), 32'(rd_t + wr_t));
    n = 0;
    while (sd_busy && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check_eq("busy_timeout", 32'(sd_busy), 32'd0);
    tick();
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd_grant"}, 32'(rd_grant), 32'd0);
    check_eq({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check_eq({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check_eq({tag, "_rd_done"}, 32'(rd_done), 32'd0);
    check_eq({tag, "_wr_grant"}, 32'(wr_grant), 32'd0);
    check_eq({tag, "_wr_ack"}, 32'(wr_ack), 32'd0);
    check_eq({tag, "_wr_done"}, 32'(wr_done), 32'd0);
    check_eq({tag, "_sd_enable"}, 32'(sd_enable), 32'd0);
    check_eq({tag, "_sd_rw"}, 32'(sd_rw), 32'd0);
    check_eq({tag, "_sd_addr"}, 32'(sd_addr), 32'd0);
    check_eq({tag, "_sd_data"}, 32'(sd_data), 32'd0);
  endtask

  task automatic check_drained(input string tag);
    check_eq({tag, "_gq_left"}, 32'(gq.size()), 32'd0);
    check_eq({tag, "_rq_left"}, 32'(rq.size()), 32'd0);
    check_eq({tag, "_wq_left"}, 32'(wq.size()), 32'd0);
  endtask

  initial begin
    int n;
    clear_counts();

    // Reset state.
    RST = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    RST = 1'b1;
    tick();

    // Read on an idle bus.
    clear_counts();
    rd_addr = 24'h012345;
    push_grant(1'b1, 24'h012345);
    push_rd_burst();
    rd_req = 1'b1;
    tick();
    check_eq("rd_grant_latency", 32'(rd_grant), 32'd1);
    wait_dones(1, 0, 500);
    check_eq("t1_rd_beats", 32'(rd_beats), 32'd8);
    check_eq("t1_rd_done", 32'(rd_dones), 32'd1);
    check_eq("t1_grants", 32'(grants), 32'd1);
    check_drained("t1");

    // Write with a nine-beat valid from the controller.
    clear_counts();
    wr_beats = 9;
    wr_addr = 24'h00BEEF;
    push_grant(1'b0, 24'h00BEEF);
    push_wr_burst();
    wr_req = 1'b1;
    wait_dones(0, 1, 500);
    check_eq("t2_wr_acks", 32'(wr_acks), 32'd8);
    check_eq("t2_valid_cycles", 32'(wv_cycles), 32'd9);
    check_eq("t2_wr_done", 32'(wr_dones), 32'd1);
    check_drained("t2");
    wr_beats = 8;

    // Simultaneous requests: read first, write only after the read completes.
    clear_counts();
    rd_addr = 24'h000111;
    wr_addr = 24'h000222;
    push_grant(1'b1, 24'h000111);
    push_rd_burst();
    push_grant(1'b0, 24'h000222);
    push_wr_burst();
    rd_req = 1'b1;
    wr_req = 1'b1;
    n = 0;
    while (wr_dones < 1 && n < 1000) begin
      tick();
      if (wr_grant) check_eq("t3_wr_after_rd_done", 32'(rd_dones), 32'd1);
      n++;
    end
    wait_dones(1, 1, 500);
    check_eq("t3_grants", 32'(grants), 32'd2);
    check_drained("t3");

    // Refresh pre-emption: enable must hold across the 200-cycle busy period.
    clear_counts();
    refresh_next = 1'b1;
    rd_addr = 24'h0ABCDE;
    push_grant(1'b1, 24'h0ABCDE);
    push_rd_burst();
    rd_req = 1'b1;
    wait_dones(1, 0, 1000);
    refresh_next = 1'b0;
    check_eq("t4_grants", 32'(grants), 32'd1);
    check_eq("t4_rd_beats", 32'(rd_beats), 32'd8);
    check_eq("t4_rd_done", 32'(rd_dones), 32'd1);
    check_drained("t4");

    // Reset at beat 4 of a write; re-arbitration must wait for the controller.
    clear_counts();
    wr_addr = 24'h00ABCD;
    push_grant(1'b0, 24'h00ABCD);
    push_wr_burst();
    wr_req = 1'b1;
    n = 0;
    while (wr_acks < 4 && n < 200) begin
      tick();
      n++;
    end
    check_eq("t5_acks_before_reset", 32'(wr_acks), 32'd4);
    RST = 1'b0;
    tick();
    check_all_zero("midreset");
    wq.delete();
    in_issue = 1'b0;
    tick();
    RST = 1'b1;
    push_grant(1'b0, 24'h00ABCD);
    push_wr_burst();
    wr_req = 1'b1;
    wait_dones(0, 1, 500);
    check_eq("t5_wr_done", 32'(wr_dones), 32'd1);
    check_eq("t5_grants", 32'(grants), 32'd2);
    check_drained("t5");

    // Both requests held continuously for four grants.
    clear_counts();
    rd_addr = 24'h000100;
    wr_addr = 24'h000200;
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 0; i < 2; i++) begin
      push_grant(1'b1, 24'h000100);
      push_rd_burst();
      push_grant(1'b0, 24'h000200);
      push_wr_burst();
    end
`else
    for (int i = 0; i < 4; i++) begin
      push_grant(1'b1, 24'h000100);
      push_rd_burst();
    end
`endif
    hold_reqs = 1'b1;
    rd_req = 1'b1;
    wr_req = 1'b1;
    n = 0;
    while (grants < 4 && n < 2000) begin
      tick();
      n++;
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    hold_reqs = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    wait_dones(2, 2, 500);
`else
    wait_dones(4, 0, 500);
`endif
    check_eq("t6_grants", 32'(grants), 32'd4);
    check_drained("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
